// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: register/data widths, instruction field positions,
// the ID/EX pipeline register layout and the register-match helper.
package pipeline_pkg;

  localparam int DW_C = 32;
  localparam int RW_C = 5;

  localparam logic [RW_C-1:0] REG_ZERO = '0;

  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_W   = 16;

  typedef struct packed {
    logic            valid;
    logic [DW_C-1:0] pc;
    logic [DW_C-1:0] rs_val;
    logic [DW_C-1:0] rt_val;
    logic [DW_C-1:0] imm;
    logic [RW_C-1:0] rs;
    logic [RW_C-1:0] rt;
    logic [RW_C-1:0] rd;
  } id_ex_t;

  // $0 is hardwired, so a producer targeting it never matches a reader.
  function automatic logic reg_match(input logic [RW_C-1:0] src,
                                     input logic [RW_C-1:0] dst);
    return (src != REG_ZERO) && (src == dst);
  endfunction

endpackage

// File: rtl/id_operand_stage_fwd_mux.sv
// One-operand source select (EX > MEM > WB > register file) plus producer-match flags.
// Forwarding paths exist only when OPERAND_BYPASS_EN is defined.
module operand_fwd_mux
  import pipeline_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic [RW-1:0] src_i,
  input  logic          ex_fwd_i,
  input  logic          ex_load_i,
  input  logic [RW-1:0] ex_dst_i,
  input  logic [DW-1:0] ex_data_i,
  input  logic          mem_fwd_i,
  input  logic [RW-1:0] mem_dst_i,
  input  logic [DW-1:0] mem_data_i,
  input  logic          wb_fwd_i,
  input  logic [RW-1:0] wb_dst_i,
  input  logic [DW-1:0] wb_data_i,
  input  logic [DW-1:0] rf_data_i,
  output logic [DW-1:0] val_o,
  output logic          load_hit_o,
  output logic          busy_hit_o
);

  logic ex_m, mem_m, wb_m;

  assign ex_m  = ex_fwd_i  & reg_match(src_i, ex_dst_i);
  assign mem_m = mem_fwd_i & reg_match(src_i, mem_dst_i);
  assign wb_m  = wb_fwd_i  & reg_match(src_i, wb_dst_i);

  assign load_hit_o = ex_m & ex_load_i;
  assign busy_hit_o = ex_m | mem_m | wb_m;

`ifdef OPERAND_BYPASS_EN
  // A load in EX has no data yet; it is covered by the load-use stall instead.
  always_comb begin
    val_o = rf_data_i;
    if (src_i == REG_ZERO)         val_o = '0;
    else if (ex_m && !ex_load_i)   val_o = ex_data_i;
    else if (mem_m)                val_o = mem_data_i;
    else if (wb_m)                 val_o = wb_data_i;
  end
`else
  logic unused_fwd_data;
  assign unused_fwd_data = ^{ex_data_i, mem_data_i, wb_data_i};
  assign val_o = rf_data_i;
`endif

endmodule

// File: rtl/id_operand_stage.sv
// MIPS decode/operand-fetch stage: register-file addressing, operand bypass, hazard
// stall and the ID/EX register. OPERAND_BYPASS_EN enables EX/MEM/WB forwarding.
module id_operand_stage
  import pipeline_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_D,
  input  logic [DW-1:0] instr_D,
  input  logic [DW-1:0] pc_D,
  output logic [RW-1:0] A1,
  output logic [RW-1:0] A2,
  input  logic [DW-1:0] rd1,
  input  logic [DW-1:0] rd2,
  input  logic          ex_valid,
  input  logic          ex_we,
  input  logic          ex_is_load,
  input  logic [RW-1:0] ex_dst,
  input  logic [DW-1:0] ex_data,
  input  logic          mem_valid,
  input  logic          mem_we,
  input  logic [RW-1:0] mem_dst,
  input  logic [DW-1:0] mem_data,
  input  logic          wb_we,
  input  logic [RW-1:0] wb_dst,
  input  logic [DW-1:0] wb_data,
  input  logic          stall_E,
  input  logic          flush_E,
  output logic          stall_D,
  output logic          valid_E,
  output logic [DW-1:0] pc_E,
  output logic [DW-1:0] rs_val_E,
  output logic [DW-1:0] rt_val_E,
  output logic [DW-1:0] imm_E,
  output logic [RW-1:0] rs_E,
  output logic [RW-1:0] rt_E,
  output logic [RW-1:0] rd_E,
  output logic [31:0]   stall_cnt
);

  logic [RW-1:0] rs, rt, rd;
  logic [DW-1:0] imm_ext;
  logic          ex_fwd, mem_fwd;
  logic [DW-1:0] rs_val, rt_val;
  logic          rs_load, rt_load, rs_busy, rt_busy;
  logic          hazard;

  assign rs      = instr_D[RS_MSB:RS_LSB];
  assign rt      = instr_D[RT_MSB:RT_LSB];
  assign rd      = instr_D[RD_MSB:RD_LSB];
  assign imm_ext = {{(DW-IMM_W){instr_D[IMM_MSB]}}, instr_D[IMM_MSB:0]};
  assign A1      = rs;
  assign A2      = rt;

  assign ex_fwd  = ex_valid & ex_we;
  assign mem_fwd = mem_valid & mem_we;

  operand_fwd_mux #(.DW(DW), .RW(RW)) u_rs_mux (
    .src_i(rs), .ex_fwd_i(ex_fwd), .ex_load_i(ex_is_load), .ex_dst_i(ex_dst),
    .ex_data_i(ex_data), .mem_fwd_i(mem_fwd), .mem_dst_i(mem_dst),
    .mem_data_i(mem_data), .wb_fwd_i(wb_we), .wb_dst_i(wb_dst),
    .wb_data_i(wb_data), .rf_data_i(rd1), .val_o(rs_val),
    .load_hit_o(rs_load), .busy_hit_o(rs_busy)
  );

  operand_fwd_mux #(.DW(DW), .RW(RW)) u_rt_mux (
    .src_i(rt), .ex_fwd_i(ex_fwd), .ex_load_i(ex_is_load), .ex_dst_i(ex_dst),
    .ex_data_i(ex_data), .mem_fwd_i(mem_fwd), .mem_dst_i(mem_dst),
    .mem_data_i(mem_data), .wb_fwd_i(wb_we), .wb_dst_i(wb_dst),
    .wb_data_i(wb_data), .rf_data_i(rd2), .val_o(rt_val),
    .load_hit_o(rt_load), .busy_hit_o(rt_busy)
  );

`ifdef OPERAND_BYPASS_EN
  logic unused_sig;
  assign unused_sig = ^{instr_D[DW-1:RS_MSB+1], rs_busy, rt_busy};
  assign hazard = valid_D & (rs_load | rt_load);
`else
  // Without forwarding, any in-flight writer of a source register blocks decode.
  logic unused_sig;
  assign unused_sig = ^{instr_D[DW-1:RS_MSB+1], rs_load, rt_load};
  assign hazard = valid_D & (rs_busy | rt_busy);
`endif

  assign stall_D = hazard | stall_E;

  id_ex_t      id_ex_q, id_ex_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    id_ex_d = id_ex_q;
    if (flush_E) begin
      id_ex_d = '0;
    end else if (!stall_E) begin
      if (hazard) begin
        id_ex_d = '0;
      end else begin
        id_ex_d.valid  = valid_D;
        id_ex_d.pc     = pc_D;
        id_ex_d.rs_val = rs_val;
        id_ex_d.rt_val = rt_val;
        id_ex_d.imm    = imm_ext;
        id_ex_d.rs     = rs;
        id_ex_d.rt     = rt;
        id_ex_d.rd     = rd;
      end
    end
  end

  // A squashed hazard cycle is not a real stall, so flush suppresses the count.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard && !flush_E && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_ex_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      id_ex_q     <= id_ex_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign valid_E   = id_ex_q.valid;
  assign pc_E      = id_ex_q.pc;
  assign rs_val_E  = id_ex_q.rs_val;
  assign rt_val_E  = id_ex_q.rt_val;
  assign imm_E     = id_ex_q.imm;
  assign rs_E      = id_ex_q.rs;
  assign rt_E      = id_ex_q.rt;
  assign rd_E      = id_ex_q.rd;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Scoreboard bench for id_operand_stage; expectations follow OPERAND_BYPASS_EN.
module tb_id_operand_stage;

  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk, rst;
  logic          valid_D;
  logic [DW-1:0] instr_D, pc_D;
  logic [RW-1:0] A1, A2;
  logic [DW-1:0] rd1, rd2;
  logic          ex_valid, ex_we, ex_is_load;
  logic [RW-1:0] ex_dst;
  logic [DW-1:0] ex_data;
  logic          mem_valid, mem_we;
  logic [RW-1:0] mem_dst;
  logic [DW-1:0] mem_data;
  logic          wb_we;
  logic [RW-1:0] wb_dst;
  logic [DW-1:0] wb_data;
  logic          stall_E, flush_E, stall_D, valid_E;
  logic [DW-1:0] pc_E, rs_val_E, rt_val_E, imm_E;
  logic [RW-1:0] rs_E, rt_E, rd_E;
  logic [31:0]   stall_cnt;

  id_operand_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .valid_D(valid_D), .instr_D(instr_D), .pc_D(pc_D),
    .A1(A1), .A2(A2), .rd1(rd1), .rd2(rd2),
    .ex_valid(ex_valid), .ex_we(ex_we), .ex_is_load(ex_is_load),
    .ex_dst(ex_dst), .ex_data(ex_data),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_dst(mem_dst), .mem_data(mem_data),
    .wb_we(wb_we), .wb_dst(wb_dst), .wb_data(wb_data),
    .stall_E(stall_E), .flush_E(flush_E), .stall_D(stall_D),
    .valid_E(valid_E), .pc_E(pc_E), .rs_val_E(rs_val_E), .rt_val_E(rt_val_E),
    .imm_E(imm_E), .rs_E(rs_E), .rt_E(rt_E), .rd_E(rd_E), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, rs_val, rt_val, imm;
    logic [4:0]  rs, rt, rd;
  } exp_t;

  exp_t sb[$];
  int   errors  = 0;
  int   checks  = 0;
  int   exp_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    end
  endtask

  // Monitor: one pop per instruction captured into ID/EX (held cycles are skipped).
  always @(posedge clk) begin : monitor
    logic hold;
    hold = stall_E & ~flush_E;
    #1;
    if (!rst && valid_E === 1'b1 && !hold) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_valid", pc_E, 32'hFFFF_FFFF);
      end else begin : pop
        exp_t e;
        e = sb.pop_front();
        chk("E_pc",     pc_E,            e.pc);
        chk("E_rs_val", rs_val_E,        e.rs_val);
        chk("E_rt_val", rt_val_E,        e.rt_val);
        chk("E_imm",    imm_E,           e.imm);
        chk("E_regs",   {17'd0, rs_E, rt_E, rd_E}, {17'd0, e.rs, e.rt, e.rd});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_D = 0; instr_D = 0; pc_D = 0; rd1 = 0; rd2 = 0;
    ex_valid = 0; ex_we = 0; ex_is_load = 0; ex_dst = 0; ex_data = 0;
    mem_valid = 0; mem_we = 0; mem_dst = 0; mem_data = 0;
    wb_we = 0; wb_dst = 0; wb_data = 0; stall_E = 0; flush_E = 0;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [15:0] imm, input logic [31:0] pc);
    valid_D = 1'b1;
    instr_D = {6'h08, rs, rt, imm};
    pc_D    = pc;
  endtask

  // Expected ID/EX contents for the instruction currently on the D inputs.
  task automatic accept(input string name, input logic [31:0] rsv, input logic [31:0] rtv);
    exp_t e;
    chk({name, "_stall_D"}, {31'd0, stall_D}, 32'd0);
    e.pc     = pc_D;
    e.rs_val = rsv;
    e.rt_val = rtv;
    e.imm    = {{16{instr_D[15]}}, instr_D[15:0]};
    e.rs     = instr_D[25:21];
    e.rt     = instr_D[20:16];
    e.rd     = instr_D[15:11];
    sb.push_back(e);
    step();
  endtask

  task automatic bubble(input string name);
    chk({name, "_stall_D"}, {31'd0, stall_D}, 32'd1);
    step();
    exp_cnt++;
    chk({name, "_valid_E"}, {31'd0, valid_E}, 32'd0);
    chk({name, "_cnt"}, stall_cnt, exp_cnt);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #12;
    chk("rst_valid_E", {31'd0, valid_E}, 32'd0);
    chk("rst_pc_E", pc_E, 32'd0);
    chk("rst_rs_val_E", rs_val_E, 32'd0);
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Plain instruction, operands straight from the register file.
    issue(5'd1, 5'd2, 16'h1800, 32'h100);
    rd1 = 32'h1234; rd2 = 32'h5678;
    #1;
    chk("A1", {27'd0, A1}, 32'd1);
    chk("A2", {27'd0, A2}, 32'd2);
    accept("plain", 32'h1234, 32'h5678);

    // ALU result for $3 in EX.
    idle();
    issue(5'd3, 5'd0, 16'h8000, 32'h104);
    ex_valid = 1; ex_we = 1; ex_dst = 5'd3; ex_data = 32'h11;
    #1;
`ifdef OPERAND_BYPASS_EN
    accept("ex_fwd", 32'h11, 32'h0);
`else
    bubble("ex_wait1");
    ex_valid = 0; ex_we = 0;
    mem_valid = 1; mem_we = 1; mem_dst = 5'd3; mem_data = 32'h11;
    #1;
    bubble("ex_wait2");
    mem_valid = 0; mem_we = 0;
    wb_we = 1; wb_dst = 5'd3; wb_data = 32'h11;
    #1;
    bubble("ex_wait3");
    wb_we = 0; rd1 = 32'h11;
    #1;
    accept("ex_rf", 32'h11, 32'h0);
`endif

    // Load-use on rt.
    idle();
    issue(5'd0, 5'd5, 16'h0004, 32'h108);
    ex_valid = 1; ex_we = 1; ex_is_load = 1; ex_dst = 5'd5; ex_data = 32'hDEAD;
    #1;
    bubble("lu");
    chk("lu_bubble_pc", pc_E, 32'd0);
    ex_valid = 0; ex_we = 0; ex_is_load = 0;
    mem_valid = 1; mem_we = 1; mem_dst = 5'd5; mem_data = 32'hABCD;
    #1;
`ifdef OPERAND_BYPASS_EN
    accept("lu_mem_fwd", 32'h0, 32'hABCD);
`else
    bubble("lu_wait2");
    mem_valid = 0; mem_we = 0;
    wb_we = 1; wb_dst = 5'd5; wb_data = 32'hABCD;
    #1;
    bubble("lu_wait3");
    wb_we = 0; rd2 = 32'hABCD;
    #1;
    accept("lu_rf", 32'h0, 32'hABCD);
`endif

    // EX and MEM both write $7.
    idle();
    issue(5'd7, 5'd0, 16'hFFFF, 32'h10C);
    ex_valid = 1; ex_we = 1; ex_dst = 5'd7; ex_data = 32'h1;
    mem_valid = 1; mem_we = 1; mem_dst = 5'd7; mem_data = 32'h2;
    #1;
`ifdef OPERAND_BYPASS_EN
    accept("prio_ex", 32'h1, 32'h0);
`else
    bubble("prio_wait");
`endif

    // Producers targeting $0 must never feed a $0 read.
    idle();
    issue(5'd0, 5'd0, 16'h0010, 32'h110);
    ex_valid = 1; ex_we = 1; ex_dst = 5'd0; ex_data = 32'h55;
    mem_valid = 1; mem_we = 1; mem_dst = 5'd0; mem_data = 32'h66;
    #1;
    accept("zero_reg", 32'h0, 32'h0);

    // WB write of $9 while the register file still shows the old value.
    idle();
    issue(5'd9, 5'd2, 16'h0020, 32'h114);
    wb_we = 1; wb_dst = 5'd9; wb_data = 32'h99; rd2 = 32'h22;
    #1;
`ifdef OPERAND_BYPASS_EN
    accept("wb_fwd", 32'h99, 32'h22);
`else
    bubble("wb_wait");
    wb_we = 0; rd1 = 32'h99;
    #1;
    accept("wb_rf", 32'h99, 32'h22);
`endif
    issue(5'd9, 5'd2, 16'h0020, 32'h118);
    wb_we = 0; wb_dst = 5'd9; wb_data = 32'h99; rd1 = 32'h44; rd2 = 32'h22;
    #1;
    accept("wb_stalled", 32'h44, 32'h22);

    // Execute back-pressure holds ID/EX without counting stalls.
    idle();
    issue(5'd4, 5'd6, 16'h0008, 32'h11C);
    rd1 = 32'h40; rd2 = 32'h60;
    #1;
    accept("pre_hold", 32'h40, 32'h60);
    issue(5'd1, 5'd1, 16'h0000, 32'h120);
    stall_E = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_stall_D", {31'd0, stall_D}, 32'd1);
      step();
      chk("hold_pc_E", pc_E, 32'h11C);
      chk("hold_rs_val_E", rs_val_E, 32'h40);
      chk("hold_cnt", stall_cnt, exp_cnt);
    end
    flush_E = 1;
    step();
    chk("flush_over_stall_valid", {31'd0, valid_E}, 32'd0);
    chk("flush_over_stall_pc", pc_E, 32'd0);

    // Hazard cycle squashed by flush is not counted.
    idle();
    issue(5'd0, 5'd5, 16'h0000, 32'h124);
    ex_valid = 1; ex_we = 1; ex_is_load = 1; ex_dst = 5'd5;
    flush_E = 1;
    #1;
    chk("flush_hz_stall_D", {31'd0, stall_D}, 32'd1);
    step();
    chk("flush_hz_valid", {31'd0, valid_E}, 32'd0);
    chk("flush_hz_cnt", stall_cnt, exp_cnt);

    // Asynchronous reset while a stalled instruction sits in ID/EX.
    idle();
    issue(5'd1, 5'd2, 16'h0001, 32'h128);
    rd1 = 32'h1; rd2 = 32'h2;
    #1;
    accept("pre_rst", 32'h1, 32'h2);
    issue(5'd0, 5'd5, 16'h0000, 32'h12C);
    ex_valid = 1; ex_we = 1; ex_is_load = 1; ex_dst = 5'd5;
    stall_E = 1;
    step();
    exp_cnt++;
    chk("pre_rst_cnt", stall_cnt, exp_cnt);
    chk("pre_rst_valid", {31'd0, valid_E}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, valid_E}, 32'd0);
    chk("mid_rst_cnt", stall_cnt, 32'd0);
    chk("mid_rst_pc", pc_E, 32'd0);
    chk("mid_rst_stall_D", {31'd0, stall_D}, 32'd1);
    exp_cnt = 0;
    rst = 1'b0;
    idle();
    step();
    step();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
